// File: rtl/splitter_stream.sv
// Streaming beam-splitter grid evaluator: one cell per handshake, per-column beam counts, reduced on drain.
// Latency: column c-1 is written when cell c (or line end) is accepted; result_valid rises LINE_LENGTH+1 cycles after drain is sampled.
// Backpressure: in_ready = RUN && !drain; tokens are held off while draining and ignored in DONE.
//
// Ports: clock/reset (async, active-high)/clear (sync); in_valid/in_ready/in_code cell stream;
//        drain request; result_valid, timelines, splits, overflow, format_err results.
module splitter_stream #(
    parameter int LINE_LENGTH = 141,
    parameter int COUNT_W     = 64,
    parameter int SPLIT_W     = 32,
    parameter int IDX_W       = $clog2(LINE_LENGTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_code,
    input  logic               drain,
    output logic               result_valid,
    output logic [COUNT_W-1:0] timelines,
    output logic [SPLIT_W-1:0] splits,
    output logic               overflow,
    output logic               format_err
);
    localparam logic [1:0]       C_SPLIT  = 2'b01;
    localparam logic [1:0]       C_SRC    = 2'b10;
    localparam logic [1:0]       C_EOL    = 2'b11;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LENGTH);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [COUNT_W-1:0] cols [LINE_LENGTH];
    logic [IDX_W-1:0]   col_idx;
    logic [IDX_W-1:0]   drain_idx;
    // One-column-lag pipeline: code/old value of cell c-1, and what cell c-2 splits into c-1.
    logic [1:0]         prev_code;
    logic [COUNT_W-1:0] prev_old;
    logic [COUNT_W-1:0] pend_left;

    logic               accept, is_eol, cell_ok, eol_ok, fmt_bad, col_wr, split_hit;
    logic [IDX_W-1:0]   wr_idx;
    logic [COUNT_W-1:0] old_cur, drain_col, prev_keep, right_in;
    logic [COUNT_W+1:0] col_sum;
    logic [COUNT_W:0]   tl_sum;
    logic [SPLIT_W:0]   split_sum;

    assign in_ready     = (state == S_RUN) && !drain;
    assign result_valid = (state == S_DONE);

    assign accept    = in_valid && in_ready;
    assign is_eol    = (in_code == C_EOL);
    assign cell_ok   = accept && !is_eol && (col_idx != LAST_IDX);
    assign eol_ok    = accept && is_eol && (col_idx == LAST_IDX);
    assign fmt_bad   = (accept && (is_eol ? (col_idx != LAST_IDX) : (col_idx == LAST_IDX)))
                     || ((state == S_RUN) && drain && (col_idx != '0));
    // Column 0 has no left neighbour to finalize; line end finalizes the last column.
    assign col_wr    = (cell_ok && (col_idx != '0)) || eol_ok;
    assign wr_idx    = col_idx - IDX_W'(1);
    assign split_hit = cell_ok && (in_code == C_SPLIT) && (old_cur != '0);

    // Mux-based column reads keep the index width independent of LINE_LENGTH.
    always_comb begin
        old_cur   = '0;
        drain_col = '0;
        for (int i = 0; i < LINE_LENGTH; i++) begin
            if (col_idx == IDX_W'(i))   old_cur   = cols[i];
            if (drain_idx == IDX_W'(i)) drain_col = cols[i];
        end
    end

    // new[c-1] = kept beam + left split + right split (zero at line end) + source.
    assign prev_keep = (prev_code != C_SPLIT) ? prev_old : '0;
    assign right_in  = (cell_ok && (in_code == C_SPLIT)) ? old_cur : '0;
    assign col_sum   = {2'b00, prev_keep} + {2'b00, pend_left} + {2'b00, right_in}
                     + {{(COUNT_W+1){1'b0}}, (prev_code == C_SRC)};
    assign tl_sum    = {1'b0, timelines} + {1'b0, drain_col};
    assign split_sum = {1'b0, splits} + {{SPLIT_W{1'b0}}, 1'b1};

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (drain) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_idx == LAST_IDX) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_RUN;
            col_idx    <= '0;
            drain_idx  <= '0;
            prev_code  <= '0;
            prev_old   <= '0;
            pend_left  <= '0;
            timelines  <= '0;
            splits     <= '0;
            overflow   <= 1'b0;
            format_err <= 1'b0;
            for (int i = 0; i < LINE_LENGTH; i++) cols[i] <= '0;
        end else if (clear) begin
            state      <= S_RUN;
            col_idx    <= '0;
            drain_idx  <= '0;
            prev_code  <= '0;
            prev_old   <= '0;
            pend_left  <= '0;
            timelines  <= '0;
            splits     <= '0;
            overflow   <= 1'b0;
            format_err <= 1'b0;
            for (int i = 0; i < LINE_LENGTH; i++) cols[i] <= '0;
        end else begin
            state <= state_nxt;

            if (col_wr) begin
                for (int i = 0; i < LINE_LENGTH; i++) begin
                    if (wr_idx == IDX_W'(i)) cols[i] <= col_sum[COUNT_W-1:0];
                end
                if (col_sum[COUNT_W+1:COUNT_W] != 2'b00) overflow <= 1'b1;
            end

            if (cell_ok) begin
                pend_left <= (prev_code == C_SPLIT) ? prev_old : '0;
                prev_code <= in_code;
                prev_old  <= old_cur;
                col_idx   <= col_idx + IDX_W'(1);
            end else if (eol_ok) begin
                pend_left <= '0;
                prev_code <= '0;
                prev_old  <= '0;
                col_idx   <= '0;
            end

            if (split_hit) begin
                splits <= split_sum[SPLIT_W-1:0];
                if (split_sum[SPLIT_W]) overflow <= 1'b1;
            end

            if (fmt_bad) format_err <= 1'b1;

            if ((state == S_RUN) && drain) begin
                drain_idx <= '0;
            end else if ((state == S_DRAIN) && (drain_idx != LAST_IDX)) begin
                timelines <= tl_sum[COUNT_W-1:0];
                if (tl_sum[COUNT_W]) overflow <= 1'b1;
                drain_idx <= drain_idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_splitter_stream.sv
// Directed bench for splitter_stream: three instances (15 cols, 5 cols, 5 cols with 2-bit counts) share stimulus.
// Each scenario clears, streams rows, drains, and compares against hand-computed results.
// Inputs driven #1 after posedge; outputs sampled there too.
module tb_splitter_stream;
    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic [1:0]  in_code;
    logic        drain;

    logic        rdy15, rv15, of15, fe15;
    logic [63:0] tl15;
    logic [31:0] sp15;
    logic        rdy5, rv5, of5, fe5;
    logic [15:0] tl5;
    logic [31:0] sp5;
    logic        rdy2, rv2, of2, fe2;
    logic [1:0]  tl2;
    logic [31:0] sp2;

    int checks = 0;
    int errors = 0;
    int rise15, rise5, rise2;
    bit gaps = 1'b0;

    splitter_stream #(.LINE_LENGTH(15), .COUNT_W(64)) dut15 (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy15),
        .in_code(in_code), .drain(drain), .result_valid(rv15), .timelines(tl15), .splits(sp15),
        .overflow(of15), .format_err(fe15));
    splitter_stream #(.LINE_LENGTH(5), .COUNT_W(16)) dut5 (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy5),
        .in_code(in_code), .drain(drain), .result_valid(rv5), .timelines(tl5), .splits(sp5),
        .overflow(of5), .format_err(fe5));
    splitter_stream #(.LINE_LENGTH(5), .COUNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
        .in_code(in_code), .drain(drain), .result_valid(rv2), .timelines(tl2), .splits(sp2),
        .overflow(of2), .format_err(fe2));

    always #5 clock = ~clock;

    string grid15 [16] = '{
        ".......S.......", "...............", ".......^.......", "...............",
        "......^.^......", "...............", ".....^.^.^.....", "...............",
        "....^.^...^....", "...............", "...^.^...^.^...", "...............",
        "..^...^.....^..", "...............", ".^.^.^.^.^...^.", "..............."};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] char_code(input byte ch);
        if (ch == "^") return 2'b01;
        if (ch == "S") return 2'b10;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_tok(input logic [1:0] code);
        int guard;
        int n;
        guard = 0;
        in_valid = 1'b1;
        in_code  = code;
        while (!rdy15 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 64'(rdy15), 64'd1);
        tick();
        in_valid = 1'b0;
        if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) tick();
        end
    endtask

    task automatic send_row(input string r);
        string s;
        s = r;
        for (int i = 0; i < s.len(); i++) send_tok(char_code(s[i]));
        send_tok(2'b11);
    endtask

    // Records the cycle (relative to the drain-sampling edge) at which each result_valid rises.
    task automatic wait_done();
        rise15 = -1; rise5 = -1; rise2 = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (rv15 && rise15 < 0) rise15 = k;
            if (rv5 && rise5 < 0)   rise5 = k;
            if (rv2 && rise2 < 0)   rise2 = k;
        end
    endtask

    task automatic do_drain();
        drain = 1'b1;
        tick();
        drain = 1'b0;
        wait_done();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic run_official(input string tag);
        for (int r = 0; r < 16; r++) send_row(grid15[r]);
        do_drain();
        check({tag, "_splits"}, 64'(sp15), 64'd21);
        check({tag, "_timelines"}, tl15, 64'd40);
        check({tag, "_fmt"}, 64'(fe15), 64'd0);
        check({tag, "_ovf"}, 64'(of15), 64'd0);
        check({tag, "_rise"}, 64'(rise15), 64'd16);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_code = 2'b00; drain = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tick();

        // Reset state
        check("rst_rv", 64'(rv5), 64'd0);
        check("rst_tl", 64'(tl5), 64'd0);
        check("rst_sp", 64'(sp5), 64'd0);
        check("rst_ovf", 64'(of2), 64'd0);
        check("rst_fmt", 64'(fe2), 64'd0);
        check("rst_rdy", 64'({rdy15, rdy5, rdy2}), 64'd7);
        check("rst_tl2", 64'(tl2), 64'd0);
        check("rst_sp2", 64'(sp2), 64'd0);

        // Official 15-column example
        do_clear();
        run_official("official");

        // Lone source then empty rows
        do_clear();
        send_row("..S..");
        repeat (3) send_row(".....");
        do_drain();
        check("src_tl", 64'(tl5), 64'd1);
        check("src_sp", 64'(sp5), 64'd0);
        check("src_fmt", 64'(fe5), 64'd0);
        check("src_rise", 64'(rise5), 64'd6);
        check("src_rise2", 64'(rise2), 64'd6);

        // Splitter at column 0 loses its left half
        do_clear();
        send_row("S....");
        send_row("^....");
        do_drain();
        check("edge_tl", 64'(tl5), 64'd1);
        check("edge_sp", 64'(sp5), 64'd1);

        // Dark splitters do not count; only the lit one does
        do_clear();
        send_row("..S..");
        send_row(".^.^.");
        send_row("..^..");
        do_drain();
        check("dark_sp", 64'(sp5), 64'd1);
        check("dark_tl", 64'(tl5), 64'd2);

        // Stacked pyramids: exact in 16 bits, wraps in 2 bits
        do_clear();
        send_row("..S..");
        send_row("..^..");
        send_row(".^.^.");
        send_row("..^..");
        send_row(".^.^.");
        send_row("..^..");
        do_drain();
        check("pyr_tl", 64'(tl5), 64'd14);
        check("pyr_sp", 64'(sp5), 64'd7);
        check("pyr_ovf16", 64'(of5), 64'd0);
        check("pyr_ovf2", 64'(of2), 64'd1);

        // DONE ignores drain and tokens
        drain = 1'b1; in_valid = 1'b1; in_code = 2'b10;
        check("done_rdy", 64'(rdy5), 64'd0);
        repeat (3) tick();
        drain = 1'b0; in_valid = 1'b0;
        check("done_hold_tl", 64'(tl5), 64'd14);
        check("done_hold_rv", 64'(rv5), 64'd1);

        // Clear in DONE
        do_clear();
        check("clr_rv", 64'(rv5), 64'd0);
        check("clr_tl", 64'(tl5), 64'd0);
        check("clr_sp", 64'(sp5), 64'd0);
        check("clr_ovf", 64'(of2), 64'd0);
        check("clr_rdy", 64'(rdy5), 64'd1);

        // Drain blocks a same-cycle cell
        send_row("..S..");
        in_valid = 1'b1; in_code = 2'b10; drain = 1'b1;
        #1;
        check("drain_blocks_rdy", 64'(rdy5), 64'd0);
        tick();
        drain = 1'b0; in_valid = 1'b0;
        wait_done();
        check("drain_blocks_tl", 64'(tl5), 64'd1);
        check("drain_blocks_fmt", 64'(fe5), 64'd0);

        // Six cells in a five-column row
        do_clear();
        send_row("......");
        do_drain();
        check("long_row_fmt", 64'(fe5), 64'd1);

        // Empty row is flagged and leaves columns intact
        do_clear();
        send_row("..S..");
        send_tok(2'b11);
        do_drain();
        check("empty_row_fmt", 64'(fe5), 64'd1);
        check("empty_row_tl", 64'(tl5), 64'd1);

        // Async reset mid-row discards everything
        do_clear();
        send_row("..S..");
        send_tok(2'b00);
        send_tok(2'b00);
        send_tok(2'b01);
        check("mid_sp_before", 64'(sp5), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_sp", 64'(sp5), 64'd0);
        check("arst_rv", 64'(rv5), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        do_drain();
        check("arst_tl", 64'(tl5), 64'd0);
        check("arst_fmt", 64'(fe5), 64'd0);

        // Random gaps give identical results
        do_clear();
        gaps = 1'b1;
        run_official("gaps");
        gaps = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
